// File: rtl/intro_sequencer.sv
// intro_sequencer: steps through NUM_PAGES left/right image pairs, one new
// half-page every DWELL frames or on a key_adv rising edge, while the game
// status equals INTRO_STATUS. Also decodes the current pixel against the two
// image panels and produces the per-image ROM address.
//
// Ports:
//   frame_clk     in   one edge per video frame (sole clock)
//   Reset         in   asynchronous, active-high reset
//   status        in   game status code
//   key_adv       in   level advance request (rising edge skips the dwell)
//   DrawX, DrawY  in   current pixel coordinates
//   left_img      out  image number in the left panel (0 = none)
//   right_img     out  image number in the right panel (0 = none)
//   is_left       out  pixel lies in an active left panel
//   is_right      out  pixel lies in an active right panel
//   intro_address out  ROM address of the pixel within its panel image
//   intro_done    out  sequence has completed
module intro_sequencer #(
  parameter int unsigned NUM_PAGES    = 5,
  parameter int unsigned DWELL        = 300,
  parameter int unsigned IMG_W        = 199,
  parameter int unsigned IMG_H        = 107,
  parameter int unsigned LX0          = 79,
  parameter int unsigned RX0          = 360,
  parameter int unsigned Y0           = 80,
  parameter logic [3:0]  INTRO_STATUS = 4'd2,
  parameter int unsigned ADDR_W       = 20
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [3:0]        status,
  input  logic              key_adv,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [4:0]        left_img,
  output logic [4:0]        right_img,
  output logic              is_left,
  output logic              is_right,
  output logic [ADDR_W-1:0] intro_address,
  output logic              intro_done
);

  localparam int unsigned CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [3:0] LAST_PAGE = 4'(NUM_PAGES - 1);

  // Window bounds at 11 bits so RX0 + IMG_W cannot overflow.
  localparam logic [10:0] LX_LO = 11'(LX0);
  localparam logic [10:0] LX_HI = 11'(LX0 + IMG_W);
  localparam logic [10:0] RX_LO = 11'(RX0);
  localparam logic [10:0] RX_HI = 11'(RX0 + IMG_W);
  localparam logic [10:0] Y_LO  = 11'(Y0);
  localparam logic [10:0] Y_HI  = 11'(Y0 + IMG_H);

  typedef enum logic [1:0] {StIdle, StShowL, StShowLr, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       page_q, page_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       left_q, left_d;
  logic [4:0]       right_q, right_d;
  logic             done_q, done_d;
  logic             adv_q;

  logic active;
  logic step;

  assign active = (status == INTRO_STATUS);
  // Counter terminal and key edge OR together, so a coincidence is one step.
  assign step   = (cnt_q == CNT_LAST) || (key_adv && !adv_q);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      page_q  <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      done_q  <= 1'b0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      done_q  <= done_d;
      adv_q   <= key_adv;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    right_d = right_q;
    done_d  = done_q;
    if (!active) begin
      state_d = StIdle;
      page_d  = '0;
      cnt_d   = '0;
      left_d  = '0;
      right_d = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StShowL;
          page_d  = '0;
          cnt_d   = '0;
          left_d  = 5'd1;
          right_d = '0;
          done_d  = 1'b0;
        end
        StShowL: begin
          if (step) begin
            state_d = StShowLr;
            right_d = {page_q, 1'b0} + 5'd2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StShowLr: begin
          if (step) begin
            cnt_d = '0;
            if (page_q < LAST_PAGE) begin
              state_d = StShowL;
              page_d  = page_q + 4'd1;
              left_d  = {page_q, 1'b0} + 5'd3;
              right_d = '0;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          // Hold everything until status leaves the intro code.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign left_img   = left_q;
  assign right_img  = right_q;
  assign intro_done = done_q;

  // Pixel decode uses geometry only; the image number gates just is_left/is_right.
  logic [10:0]       x_ext, y_ext;
  logic              in_y, in_lwin, in_rwin;
  logic [ADDR_W-1:0] dy_a;

  assign x_ext   = {1'b0, DrawX};
  assign y_ext   = {1'b0, DrawY};
  assign in_y    = (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign in_lwin = in_y && (x_ext >= LX_LO) && (x_ext < LX_HI);
  assign in_rwin = in_y && (x_ext >= RX_LO) && (x_ext < RX_HI);
  assign dy_a    = ADDR_W'(DrawY) - ADDR_W'(Y0);

  always_comb begin
    intro_address = '0;
    if (in_lwin) begin
      intro_address = (ADDR_W'(DrawX) - ADDR_W'(LX0)) + dy_a * ADDR_W'(IMG_W);
    end else if (in_rwin) begin
      intro_address = (ADDR_W'(DrawX) - ADDR_W'(RX0)) + dy_a * ADDR_W'(IMG_W);
    end
  end

  assign is_left  = active && (left_q != 5'd0) && in_lwin;
  assign is_right = active && (right_q != 5'd0) && in_rwin;

endmodule

// File: tb/tb_intro_sequencer.sv
module tb_intro_sequencer;

  logic        frame_clk;
  logic        Reset;
  logic [3:0]  status;
  logic        key_adv;
  logic [9:0]  DrawX, DrawY;
  logic [4:0]  left_img, right_img;
  logic        is_left, is_right;
  logic [19:0] intro_address;
  logic        intro_done;

  intro_sequencer #(
    .NUM_PAGES(2),
    .DWELL    (4)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .status       (status),
    .key_adv      (key_adv),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .left_img     (left_img),
    .right_img    (right_img),
    .is_left      (is_left),
    .is_right     (is_right),
    .intro_address(intro_address),
    .intro_done   (intro_done)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string       name;
    bit          pix;
    logic [4:0]  l;
    logic [4:0]  r;
    logic        d;
    logic        il;
    logic        ir;
    logic [19:0] a;
  } item_t;

  item_t exp_q[$];
  event  chk_ev;
  int    n_vec = 0;
  int    n_bad = 0;
  item_t mon_it;

  // Monitor: pops each expectation as it is posted and compares live outputs.
  initial begin
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        mon_it = exp_q.pop_front();
        n_vec++;
        if (!mon_it.pix) begin
          if (left_img !== mon_it.l || right_img !== mon_it.r || intro_done !== mon_it.d) begin
            n_bad++;
            $display("FAIL %s: got left=%0d right=%0d done=%0d, need left=%0d right=%0d done=%0d",
                     mon_it.name, left_img, right_img, intro_done, mon_it.l, mon_it.r, mon_it.d);
          end
        end else begin
          if (is_left !== mon_it.il || is_right !== mon_it.ir || intro_address !== mon_it.a) begin
            n_bad++;
            $display("FAIL %s: got is_left=%0d is_right=%0d addr=%0d, need %0d %0d %0d",
                     mon_it.name, is_left, is_right, intro_address, mon_it.il, mon_it.ir,
                     mon_it.a);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #2;
  endtask

  task automatic exp_frame(input string nm, input logic [4:0] l, input logic [4:0] r,
                           input logic d);
    item_t it;
    it.name = nm; it.pix = 1'b0; it.l = l; it.r = r; it.d = d;
    it.il = 1'b0; it.ir = 1'b0; it.a = '0;
    exp_q.push_back(it);
    -> chk_ev;
    #1;
  endtask

  task automatic exp_pix(input string nm, input int x, input int y, input logic il,
                         input logic ir, input int a);
    item_t it;
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    it.name = nm; it.pix = 1'b1; it.l = '0; it.r = '0; it.d = 1'b0;
    it.il = il; it.ir = ir; it.a = 20'(a);
    exp_q.push_back(it);
    -> chk_ev;
    #1;
  endtask

  initial begin
    Reset = 1'b1; status = 4'd0; key_adv = 1'b0; DrawX = '0; DrawY = '0;
    #2;
    exp_frame("reset", 5'd0, 5'd0, 1'b0);
    Reset = 1'b0;
    tick(1);                                   // edge 0, status rises after it
    status = 4'd2;
    tick(1); exp_frame("e1", 5'd1, 5'd0, 1'b0);
    tick(3); exp_frame("e4", 5'd1, 5'd0, 1'b0);
    tick(1); exp_frame("e5", 5'd1, 5'd2, 1'b0);
    tick(3); exp_frame("e8", 5'd1, 5'd2, 1'b0);
    tick(1); exp_frame("e9", 5'd3, 5'd0, 1'b0);
    tick(4); exp_frame("e13", 5'd3, 5'd4, 1'b0);
    tick(4); exp_frame("e17", 5'd3, 5'd4, 1'b1);
    key_adv = 1'b1;
    tick(1); exp_frame("done_key", 5'd3, 5'd4, 1'b1);
    key_adv = 1'b0;
    tick(1); exp_frame("done_hold", 5'd3, 5'd4, 1'b1);

    status = 4'd0;
    tick(1); exp_frame("stat_off", 5'd0, 5'd0, 1'b0);
    status = 4'd2;
    tick(1); exp_frame("reentry", 5'd1, 5'd0, 1'b0);
    key_adv = 1'b1;                            // rises one frame after SHOW_L entry
    tick(1); exp_frame("adv_l", 5'd1, 5'd2, 1'b0);
    key_adv = 1'b0;
    tick(3); exp_frame("adv_hold", 5'd1, 5'd2, 1'b0);
    key_adv = 1'b1;                            // coincides with counter terminal
    tick(1); exp_frame("coinc", 5'd3, 5'd0, 1'b0);
    tick(1); exp_frame("coinc_hold", 5'd3, 5'd0, 1'b0);
    key_adv = 1'b0;
    tick(2); exp_frame("coinc_hold2", 5'd3, 5'd0, 1'b0);
    tick(1); exp_frame("lr_p1", 5'd3, 5'd4, 1'b0);

    status = 4'd0;
    tick(1); exp_frame("drop", 5'd0, 5'd0, 1'b0);
    status = 4'd2;
    tick(1); exp_frame("back", 5'd1, 5'd0, 1'b0);

    key_adv = 1'b1;
    tick(1); exp_frame("pre_rst", 5'd1, 5'd2, 1'b0);
    key_adv = 1'b0;
    Reset = 1'b1;                              // between edges
    #1;
    exp_frame("async_rst", 5'd0, 5'd0, 1'b0);
    tick(1); exp_frame("rst_hold", 5'd0, 5'd0, 1'b0);
    Reset = 1'b0;
    tick(1); exp_frame("restart", 5'd1, 5'd0, 1'b0);

    exp_pix("pix_l", 80, 81, 1'b1, 1'b0, 200);
    exp_pix("pix_l_xedge", 278, 81, 1'b0, 1'b0, 0);
    exp_pix("pix_r_noimg", 360, 80, 1'b0, 1'b0, 0);
    tick(1);
    exp_pix("pix_l_corner", 277, 186, 1'b1, 1'b0, 21292);
    exp_pix("pix_l_above", 80, 79, 1'b0, 1'b0, 0);
    exp_pix("pix_l_origin", 79, 80, 1'b1, 1'b0, 0);
    key_adv = 1'b1;
    tick(1); exp_frame("to_lr", 5'd1, 5'd2, 1'b0);
    key_adv = 1'b0;
    exp_pix("pix_r", 361, 82, 1'b0, 1'b1, 399);
    exp_pix("pix_r_corner", 558, 186, 1'b0, 1'b1, 21292);
    tick(1);
    exp_pix("pix_r_xedge", 559, 186, 1'b0, 1'b0, 0);
    exp_pix("pix_yedge", 80, 187, 1'b0, 1'b0, 0);
    status = 4'd0;
    exp_pix("pix_l_gated", 80, 81, 1'b0, 1'b0, 200);
    exp_pix("pix_r_gated", 361, 82, 1'b0, 1'b0, 399);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
